echo_engine: RTL and testbench

//  Parametrised echo processor for the audio path between ADC and DAC sample streams.
//  Per input sample it mixes in one delayed, attenuated copy; the delay comes from a circular delay line.

---
 rtl/echo_pkg.sv | 20 ++
 rtl/echo_delay_line.sv | 58 +++++
 rtl/echo_engine.sv | 113 +++++++++++
 tb/tb_echo_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the echo processor: mode encodings, default I/O offsets
// and the delay_len port width helper.
package echo_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'b00,
        MODE_FF         = 2'b01,
        MODE_FB         = 2'b10,
        MODE_BYPASS_ALT = 2'b11
    } mode_t;

    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

    // delay_len must be able to express DEPTH itself
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/echo_delay_line.sv
// Circular delay line: DEPTH x WIDTH RAM with sync read, one write port, wrapping pointer,
// saturating fill counter and same-cycle write-to-read forwarding.
module echo_delay_line #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8192,
    parameter int LW    = 14
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             flush,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             primed
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_adv;
    logic [AW-1:0]    raddr;
    logic [LW-1:0]    fill;

    // A read issued alongside a write must see the post-write pointer
    always_comb begin
        ptr_adv = (LW'(ptr) == len - LW'(1)) ? '0 : ptr + AW'(1);
        raddr   = ptr;
        if (flush)
            raddr = '0;
        else if (wr_en)
            raddr = ptr_adv;
    end

    always_ff @(posedge sysclk) begin
        if (reset || flush) begin
            ptr  <= '0;
            fill <= '0;
        end else if (wr_en) begin
            ptr <= ptr_adv;
            if (fill < len)
                fill <= fill + LW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (wr_en)
            mem[ptr] <= wdata;
        if (rd_en)
            rdata_q <= (wr_en && (raddr == ptr)) ? wdata : mem[raddr];
    end

    assign rdata  = rdata_q;
    assign primed = (fill >= len);

endmodule

// File: rtl/echo_engine.sv
// Echo processor top: strobe edge detect, 2-stage pipeline, flush control and mixer.
// Optional build macro ECHO_SAT_EN: saturate y instead of wrapping it.
module echo_engine
    import echo_pkg::*;
#(
    parameter int               WIDTH      = 10,
    parameter int               DEPTH      = 8192,
    parameter int               GAIN_SHIFT = 1,
    parameter logic [WIDTH-1:0] ADC_OFFSET = WIDTH'(ADC_OFFSET_DEF),
    parameter logic [WIDTH-1:0] DAC_OFFSET = WIDTH'(DAC_OFFSET_DEF)
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        data_valid,
    input  logic [WIDTH-1:0]            data_in,
    input  logic [1:0]                  mode,
    input  logic [len_width(DEPTH)-1:0] delay_len,
    output logic [WIDTH-1:0]            data_out,
    output logic                        out_valid,
    output logic                        primed
);
    localparam int LW = len_width(DEPTH);

    logic                    dv_q;
    logic                    strobe;
    logic                    flush;
    logic                    s1_v;
    logic [LW-1:0]           len_eff;
    logic [LW-1:0]           last_len;
    mode_t                   last_mode;
    logic [WIDTH-1:0]        x_q;
    logic [WIDTH-1:0]        rdata;
    logic                    dl_primed;
    logic signed [WIDTH-1:0] d_s;
    logic signed [WIDTH-1:0] e;
    logic [WIDTH:0]          sum;
    logic [WIDTH-1:0]        y;
    logic [WIDTH-1:0]        w;

    assign strobe = data_valid & ~dv_q;

    always_comb begin
        len_eff = delay_len;
        if (delay_len == '0)
            len_eff = LW'(1);
        else if (delay_len > LW'(DEPTH))
            len_eff = LW'(DEPTH);
    end

    // Any change of setting restarts the echo history from empty
    assign flush = strobe && ((mode_t'(mode) != last_mode) || (len_eff != last_len));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            dv_q      <= 1'b0;
            s1_v      <= 1'b0;
            x_q       <= '0;
            last_mode <= MODE_BYPASS;
            last_len  <= LW'(1);
            data_out  <= DAC_OFFSET;
            out_valid <= 1'b0;
        end else begin
            dv_q      <= data_valid;
            s1_v      <= strobe;
            out_valid <= s1_v;
            if (strobe) begin
                x_q       <= data_in - ADC_OFFSET;
                last_mode <= mode_t'(mode);
                last_len  <= len_eff;
            end
            if (s1_v)
                data_out <= y + DAC_OFFSET;
        end
    end

    always_comb begin
        d_s = dl_primed ? $signed(rdata) : '0;
        e   = d_s >>> GAIN_SHIFT;
        case (last_mode)
            MODE_FF: sum = {x_q[WIDTH-1], x_q} + {e[WIDTH-1], e};
            MODE_FB: sum = {x_q[WIDTH-1], x_q} - {e[WIDTH-1], e};
            default: sum = {x_q[WIDTH-1], x_q};
        endcase
`ifdef ECHO_SAT_EN
        if (sum[WIDTH] != sum[WIDTH-1])
            y = {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}};
        else
            y = sum[WIDTH-1:0];
`else
        y = sum[WIDTH-1:0];
`endif
        w = (last_mode == MODE_FB) ? y : x_q;
    end

    echo_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_delay_line (
        .sysclk (sysclk),
        .reset  (reset),
        .flush  (flush),
        .rd_en  (strobe),
        .wr_en  (s1_v & ~reset),
        .len    (last_len),
        .wdata  (w),
        .rdata  (rdata),
        .primed (dl_primed)
    );

    assign primed = dl_primed;

endmodule

// File: tb/tb_echo_engine.sv
// Self-checking bench for echo_engine: history-queue reference model checked every cycle,
// directed sequences with literal expectations, then randomized traffic with occasional resets.
module tb_echo_engine;
    localparam int WIDTH = 10;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          sysclk = 1'b0;
    logic          reset = 1'b1;
    logic          data_valid = 1'b0;
    logic [9:0]    data_in = '0;
    logic [1:0]    mode = '0;
    logic [LW-1:0] delay_len = LW'(1);
    logic [9:0]    data_out;
    logic          out_valid;
    logic          primed;

    always #5 sysclk = ~sysclk;

    echo_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .data_valid (data_valid),
        .data_in    (data_in),
        .mode       (mode),
        .delay_len  (delay_len),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .primed     (primed)
    );

    int checks = 0;
    int errors = 0;

    // reference model: every written delay-line value since the last flush, oldest first
    int         hist[$];
    int         m_last_mode, m_last_len, prev_dv;
    int         le, x, d, e, s, y, w;
    logic       pend = 1'b0;
    logic [9:0] pend_out;
    logic       pend_primed;
    logic [9:0] exp_out = 10'h200;
    logic       exp_ov = 1'b0;
    logic       exp_primed = 1'b0;
    logic       started = 1'b0;
    logic [9:0] got[$];
    logic [9:0] exp_q[$];

    function automatic int wrap10(input int v);
        int r;
        r = v & 1023;
        if (r >= 512) r = r - 1024;
        return r;
    endfunction

    always @(posedge sysclk) begin
        if (reset) begin
            hist.delete();
            m_last_mode = 0;
            m_last_len  = 1;
            prev_dv     = 0;
            pend        = 1'b0;
            exp_out     = 10'h200;
            exp_ov      = 1'b0;
            exp_primed  = 1'b0;
        end else begin
            exp_ov = pend;
            if (pend) begin
                exp_out    = pend_out;
                exp_primed = pend_primed;
            end
            pend = 1'b0;
            if (data_valid && prev_dv == 0) begin
                le = int'(delay_len);
                if (le == 0) le = 1;
                if (le > DEPTH) le = DEPTH;
                if (int'(mode) != m_last_mode || le != m_last_len) begin
                    hist.delete();
                    exp_primed = 1'b0;
                end
                m_last_mode = int'(mode);
                m_last_len  = le;
                x = wrap10(int'(data_in) - 'h181);
                d = (hist.size() >= le) ? hist[hist.size() - le] : 0;
                e = d >>> 1;
                if (mode == 2'b01)      s = x + e;
                else if (mode == 2'b10) s = x - e;
                else                    s = x;
`ifdef ECHO_SAT_EN
                y = (s > 511) ? 511 : ((s < -512) ? -512 : s);
`else
                y = wrap10(s);
`endif
                w = (mode == 2'b10) ? y : x;
                hist.push_back(w);
                pend        = 1'b1;
                pend_out    = 10'((y + 512) & 1023);
                pend_primed = (hist.size() >= le);
            end
            prev_dv = int'(data_valid);
        end
    end

    always @(negedge sysclk) begin
        if (started) begin
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL out_valid t=%0t got %b expected %b", $time, out_valid, exp_ov);
            end
            checks++;
            if (data_out !== exp_out) begin
                errors++;
                $display("FAIL data_out t=%0t got %h expected %h", $time, data_out, exp_out);
            end
            checks++;
            if (primed !== exp_primed) begin
                errors++;
                $display("FAIL primed t=%0t got %b expected %b", $time, primed, exp_primed);
            end
            if (out_valid) got.push_back(data_out);
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_seq(input string name);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_len got %0d expected %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check_word($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        got.delete();
    endtask

    task automatic send(input int din, input int m, input int l, input int gap, input bit rst_s1);
        @(negedge sysclk);
        data_valid = 1'b1;
        data_in    = 10'(din);
        mode       = 2'(m);
        delay_len  = LW'(l);
        @(negedge sysclk);
        data_valid = 1'b0;
        if (rst_s1) begin
            reset = 1'b1;
            @(negedge sysclk);
            reset = 1'b0;
        end
        repeat (gap) @(negedge sysclk);
    endtask

    initial begin
        int cur_mode, cur_len;
        repeat (2) @(negedge sysclk);
        started = 1'b1;
        check_bit("reset_primed", primed, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_word("reset_data_out", data_out, 10'h200);
        @(negedge sysclk);
        reset = 1'b0;

        // bypass latency: out_valid two edges after the strobe
        @(negedge sysclk);
        data_valid = 1'b1; data_in = 10'h181; mode = 2'b00; delay_len = LW'(1);
        @(negedge sysclk);
        data_valid = 1'b0;
        check_bit("t1_edge1_valid", out_valid, 1'b0);
        @(negedge sysclk);
        check_bit("t1_edge2_valid", out_valid, 1'b1);
        check_word("t1_data_out", data_out, 10'h200);
        @(negedge sysclk);
        check_bit("t1_pulse_end", out_valid, 1'b0);

        do_reset();
        send('h1C1, 2, 4, 0, 0);
        repeat (11) send('h181, 2, 4, 0, 0);
        repeat (3) @(negedge sysclk);
        exp_q = '{10'h240, 10'h200, 10'h200, 10'h200, 10'h1E0, 10'h200,
                  10'h200, 10'h200, 10'h210, 10'h200, 10'h200, 10'h200};
        check_seq("t2_fb_len4");

        do_reset();
        send('h1C1, 1, 3, 0, 0);
        repeat (6) send('h181, 1, 3, 0, 0);
        repeat (3) @(negedge sysclk);
        exp_q = '{10'h240, 10'h200, 10'h200, 10'h220, 10'h200, 10'h200, 10'h200};
        check_seq("t3_ff_len3");

        for (int g = 0; g < 4; g += 3) begin
            do_reset();
            repeat (7) send('h1C1, 2, 1, g, 0);
            repeat (3) @(negedge sysclk);
            exp_q = '{10'h240, 10'h220, 10'h230, 10'h228, 10'h22C, 10'h22A, 10'h22B};
            check_seq($sformatf("t4_fb_len1_gap%0d", g));
        end

        do_reset();
        repeat (2) send('h380, 1, 1, 0, 0);
        repeat (3) @(negedge sysclk);
`ifdef ECHO_SAT_EN
        exp_q = '{10'h3FF, 10'h3FF};
`else
        exp_q = '{10'h3FF, 10'h0FE};
`endif
        check_seq("t5_overflow");

        do_reset();
        repeat (8) send('h1C1, 2, 4, 0, 0);
        repeat (3) @(negedge sysclk);
        check_bit("t6_primed_before", primed, 1'b1);
        got.delete();
        send('h1C1, 2, 6, 0, 0);
        check_bit("t6_primed_dropped", primed, 1'b0);
        repeat (5) send('h1C1, 2, 6, 0, 0);
        repeat (3) @(negedge sysclk);
        exp_q = '{10'h240, 10'h240, 10'h240, 10'h240, 10'h240, 10'h240};
        check_seq("t6_len_change");
        send('h1C1, 2, 6, 0, 1);
        check_bit("t6_rst_no_valid", out_valid, 1'b0);
        check_word("t6_rst_data_out", data_out, 10'h200);
        @(negedge sysclk);
        check_bit("t6_rst_no_late_valid", out_valid, 1'b0);

        cur_mode = 1;
        cur_len  = 3;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 29) == 0) cur_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) cur_len  = $urandom_range(0, 20);
            send($urandom_range(0, 1023), cur_mode, cur_len, $urandom_range(0, 3),
                 $urandom_range(0, 59) == 0);
        end
        repeat (4) @(negedge sysclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
